// File: rtl/symm_fetch_pkg.sv
// symm_pkg: shared types and helpers for the symmetric-matrix operand fetch sequencer.
package symm_pkg;

    localparam int SYMM_DW = 32;
    localparam int SYMM_IW = 3;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    // Beat layout for the default configuration; the top packs beats in this field order.
    typedef struct packed {
        logic [SYMM_DW-1:0] a;
        logic [SYMM_DW-1:0] b;
        logic [SYMM_DW-1:0] c;
        logic               k_last;
        logic [SYMM_IW-1:0] row_i;
        logic [SYMM_IW-1:0] col_j;
    } symm_beat_t;

endpackage

// File: rtl/symm_fetch_fifo.sv
// symm_fetch_fifo: 2-entry beat FIFO with occupancy count and synchronous flush.
module symm_fetch_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr] <= din;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign dout = mem_q[rd_ptr];

endmodule

// File: rtl/symm_fetch.sv
// symm_fetch: lower-triangle operand fetch sequencer feeding the symmetric accumulate stage.
// Define SYMM_FETCH_STALL_CNT_EN to add the stall_cnt backpressure cycle counter port.
module symm_fetch
    import symm_pkg::*;
#(
    parameter int N  = 8,
    parameter int K  = 8,
    parameter int DW = SYMM_DW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [idx_w(N*K)-1:0] a_addr,
    output logic [idx_w(K*N)-1:0] b_addr,
    output logic [idx_w(N*N)-1:0] c_addr,
    output logic                  rd_en,
    input  logic [DW-1:0]         a_rdata,
    input  logic [DW-1:0]         b_rdata,
    input  logic [DW-1:0]         c_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         Aout,
    output logic [DW-1:0]         Bout,
    output logic [DW-1:0]         Cout,
    output logic                  k_last,
`ifdef SYMM_FETCH_STALL_CNT_EN
    output logic [31:0]           stall_cnt,
`endif
    output logic [idx_w(N)-1:0]   row_i,
    output logic [idx_w(N)-1:0]   col_j
);

    localparam int IW  = idx_w(N);
    localparam int KW  = idx_w(K);
    localparam int AAW = idx_w(N*K);
    localparam int BAW = idx_w(K*N);
    localparam int CAW = idx_w(N*N);
    localparam int MW  = 1 + 2*IW;
    localparam int BW  = 3*DW + MW;

    state_t        state, state_nxt;
    logic [IW-1:0] i_q, j_q;
    logic [KW-1:0] k_q;
    logic          k_end, j_end, i_end, last_issue;
    logic          accept, issue, pop;
    logic [2:0]    occ;
    logic [1:0]    count;
    logic          vld_p1;
    logic [MW-1:0] meta_p1;
    logic [BW-1:0] head;

    assign accept    = (state == IDLE) && start;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    // Occupancy the FIFO will see once the pending read lands and this cycle's pop retires.
    assign occ       = {1'b0, count} + {2'b0, vld_p1} - {2'b0, pop};
    assign issue     = (accept || (state == FETCH)) && (occ < 3'd2);
    assign rd_en     = issue;

    assign k_end      = (k_q == KW'(K - 1));
    assign j_end      = (j_q == i_q);
    assign i_end      = (i_q == IW'(N - 1));
    assign last_issue = k_end && j_end && i_end;

    assign a_addr = AAW'(int'(i_q) * K + int'(k_q));
    assign b_addr = BAW'(int'(k_q) * N + int'(j_q));
    assign c_addr = CAW'(int'(i_q) * N + int'(j_q));

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = (issue && last_issue) ? DRAIN : FETCH;
            end
            FETCH: begin
                busy = 1'b1;
                if (issue && last_issue) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!vld_p1 && (occ == 3'd0)) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // p0 -> p1: issue address, remember beat metadata while the memory read is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            vld_p1  <= 1'b0;
            meta_p1 <= '0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= issue;
            if (issue) begin
                meta_p1 <= {k_end, i_q, j_q};
                if (!k_end) begin
                    k_q <= k_q + 1'b1;
                end else begin
                    k_q <= '0;
                    if (!j_end) begin
                        j_q <= j_q + 1'b1;
                    end else begin
                        j_q <= '0;
                        i_q <= i_end ? '0 : i_q + 1'b1;
                    end
                end
            end
        end
    end

    // p1 -> output: captured read data joins its metadata in the beat FIFO
    symm_fetch_fifo #(.W(BW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (accept),
        .push  (vld_p1),
        .din   ({a_rdata, b_rdata, c_rdata, meta_p1}),
        .pop   (pop),
        .dout  (head),
        .count (count)
    );

    assign {Aout, Bout, Cout, k_last, row_i, col_j} = head;

`ifdef SYMM_FETCH_STALL_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_symm_fetch.sv
// tb_symm_fetch: directed self-checking bench for symm_fetch (N=2,K=2 and N=4,K=4 instances).
`timescale 1ns/1ps
module tb_symm_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic        start2, busy2, done2, rd_en2, out_valid2, out_ready2, k_last2;
    logic [1:0]  a_addr2, b_addr2, c_addr2;
    logic [31:0] a_rdata2, b_rdata2, c_rdata2, aout2, bout2, cout2;
    logic [0:0]  row2, col2;

    logic        start4, busy4, done4, rd_en4, out_valid4, out_ready4, k_last4;
    logic [3:0]  a_addr4, b_addr4, c_addr4;
    logic [31:0] a_rdata4, b_rdata4, c_rdata4, aout4, bout4, cout4;
    logic [1:0]  row4, col4;

`ifdef SYMM_FETCH_STALL_CNT_EN
    logic [31:0] stall2, stall4;
`endif

    logic [31:0]  am2 [4], bm2 [4], cm2 [4];
    logic [31:0]  am4 [16], bm4 [16], cm4 [16];
    logic [100:0] exp4 [40];

    logic [31:0] tab_a2 [6] = '{32'd0, 32'd1, 32'd10, 32'd11, 32'd10, 32'd11};
    logic [31:0] tab_b2 [6] = '{32'd100, 32'd110, 32'd100, 32'd110, 32'd101, 32'd111};
    logic [31:0] tab_c2 [6] = '{32'd200, 32'd200, 32'd210, 32'd210, 32'd211, 32'd211};
    logic [2:0]  tab_m2 [6] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b011, 3'b111};

    symm_fetch #(.N(2), .K(2), .DW(32)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .a_addr(a_addr2), .b_addr(b_addr2), .c_addr(c_addr2), .rd_en(rd_en2),
        .a_rdata(a_rdata2), .b_rdata(b_rdata2), .c_rdata(c_rdata2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .Aout(aout2), .Bout(bout2), .Cout(cout2), .k_last(k_last2),
`ifdef SYMM_FETCH_STALL_CNT_EN
        .stall_cnt(stall2),
`endif
        .row_i(row2), .col_j(col2)
    );

    symm_fetch #(.N(4), .K(4), .DW(32)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .busy(busy4), .done(done4),
        .a_addr(a_addr4), .b_addr(b_addr4), .c_addr(c_addr4), .rd_en(rd_en4),
        .a_rdata(a_rdata4), .b_rdata(b_rdata4), .c_rdata(c_rdata4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .Aout(aout4), .Bout(bout4), .Cout(cout4), .k_last(k_last4),
`ifdef SYMM_FETCH_STALL_CNT_EN
        .stall_cnt(stall4),
`endif
        .row_i(row4), .col_j(col4)
    );

    always @(posedge clk) begin
        if (rd_en2) begin
            a_rdata2 <= am2[a_addr2];
            b_rdata2 <= bm2[b_addr2];
            c_rdata2 <= cm2[c_addr2];
        end
        if (rd_en4) begin
            a_rdata4 <= am4[a_addr4];
            b_rdata4 <= bm4[b_addr4];
            c_rdata4 <= cm4[c_addr4];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic build_model();
        int n;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                am2[r*2+c] = 32'(10*r + c);
                bm2[r*2+c] = 32'(100 + 10*r + c);
                cm2[r*2+c] = 32'(200 + 10*r + c);
            end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                am4[r*4+c] = 32'(10*r + c);
                bm4[r*4+c] = 32'(100 + 10*r + c);
                cm4[r*4+c] = 32'(200 + 10*r + c);
            end
        n = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j <= i; j++)
                for (int k = 0; k < 4; k++) begin
                    exp4[n] = {32'(10*i + k), 32'(100 + 10*k + j), 32'(200 + 10*i + j),
                               (k == 3), 2'(i), 2'(j)};
                    n++;
                end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start2 = 1'b0; start4 = 1'b0; out_ready2 = 1'b0; out_ready4 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy4, done4, rd_en4, out_valid4} !== 4'b0)
            $display("FAIL reset_ctrl4: got %b want 0000", {busy4, done4, rd_en4, out_valid4});
        checks++;
        if ({a_addr4, b_addr4, c_addr4} !== 12'h0)
            $display("FAIL reset_addr4: got %h want 000", {a_addr4, b_addr4, c_addr4});
        checks++;
        if ({aout4, bout4, cout4, k_last4, row4, col4} !== 101'h0)
            $display("FAIL reset_data4: got %h want 0", {aout4, bout4, cout4, k_last4, row4, col4});
        checks++;
        if ({busy2, done2, rd_en2, out_valid2} !== 4'b0)
            $display("FAIL reset_ctrl2: got %b want 0000", {busy2, done2, rd_en2, out_valid2});
        checks++;
        if ({a_addr2, b_addr2, c_addr2, aout2, bout2, cout2, k_last2, row2, col2} !== 105'h0)
            $display("FAIL reset_out2: got %h want 0",
                     {a_addr2, b_addr2, c_addr2, aout2, bout2, cout2, k_last2, row2, col2});
`ifdef SYMM_FETCH_STALL_CNT_EN
        checks++;
        if ({stall2, stall4} !== 64'h0)
            $display("FAIL reset_stall: got %h want 0", {stall2, stall4});
`endif
        errors = errors + 0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic_n2();
        int n = 0;
        int nd = 0;
        out_ready2 = 1'b1;
        start2 = 1'b1;
        for (int cyc = 0; cyc < 60 && nd == 0; cyc++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (done2) nd++;
            if (out_valid2 && out_ready2) begin
                if (n < 6) begin
                    checks++;
                    if ({aout2, bout2, cout2} !== {tab_a2[n], tab_b2[n], tab_c2[n]}) begin
                        errors++;
                        $display("FAIL n2_data beat %0d: got %0d/%0d/%0d want %0d/%0d/%0d", n,
                                 aout2, bout2, cout2, tab_a2[n], tab_b2[n], tab_c2[n]);
                    end
                    checks++;
                    if ({k_last2, row2, col2} !== tab_m2[n]) begin
                        errors++;
                        $display("FAIL n2_meta beat %0d: got %b want %b", n,
                                 {k_last2, row2, col2}, tab_m2[n]);
                    end
                end
                n++;
            end
        end
        checks++;
        if (n != 6) begin errors++; $display("FAIL n2_beats: got %0d want 6", n); end
        checks++;
        if (nd != 1) begin errors++; $display("FAIL n2_done: got %0d want 1", nd); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stream_n4();
        int  n = 0, nd = 0, first = -1, last = -1, done_cyc = -1;
        bit  gap = 1'b0;
        logic busy_at_done = 1'b1;
        out_ready4 = 1'b1;
        start4 = 1'b1;
        for (int cyc = 1; cyc < 200 && nd == 0; cyc++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (out_valid4) begin
                if (first < 0) first = cyc;
                last = cyc;
                if (n < 40) begin
                    checks++;
                    if ({aout4, bout4, cout4, k_last4, row4, col4} !== exp4[n]) begin
                        errors++;
                        $display("FAIL stream_beat %0d: got %h want %h", n,
                                 {aout4, bout4, cout4, k_last4, row4, col4}, exp4[n]);
                    end
                end
                n++;
            end else if (first >= 0 && n < 40) begin
                gap = 1'b1;
            end
            if (done4) begin nd++; done_cyc = cyc; busy_at_done = busy4; end
        end
        @(negedge clk);
        checks++;
        if (first != 2) begin errors++; $display("FAIL stream_latency: got %0d want 2", first); end
        checks++;
        if (n != 40 || gap) begin
            errors++; $display("FAIL stream_count: got %0d gap %0d want 40 gap 0", n, gap);
        end
        checks++;
        if (done_cyc != last + 1 || last != 41) begin
            errors++; $display("FAIL stream_done_cycle: got %0d want %0d", done_cyc, 42);
        end
        checks++;
        if (nd != 1) begin errors++; $display("FAIL stream_done_count: got %0d want 1", nd); end
        checks++;
        if ({busy_at_done, busy4, done4} !== 3'b000) begin
            errors++; $display("FAIL stream_busy_after: got %b want 000", {busy_at_done, busy4, done4});
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int n = 0, nd = 0, stall = 0, phase = 0;
        bit tog = 1'b0;
        out_ready4 = 1'b1;
        start4 = 1'b1;
        for (int cyc = 0; cyc < 400 && nd == 0; cyc++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (done4) nd++;
            if (phase == 0 && out_valid4 && n == 2) phase = 1;
            if (phase == 1) begin
                out_ready4 = 1'b0;
                checks++;
                if (!out_valid4 || {aout4, bout4, cout4, k_last4, row4, col4} !== exp4[2]) begin
                    errors++;
                    $display("FAIL bp_hold cycle %0d: got v=%0b %h want v=1 %h", stall, out_valid4,
                             {aout4, bout4, cout4, k_last4, row4, col4}, exp4[2]);
                end
                stall++;
                if (stall == 5) phase = 2;
            end else if (phase == 2) begin
                tog = ~tog;
                out_ready4 = tog;
            end
            if (out_valid4 && out_ready4) begin
                if (n < 40) begin
                    checks++;
                    if ({aout4, bout4, cout4, k_last4, row4, col4} !== exp4[n]) begin
                        errors++;
                        $display("FAIL bp_beat %0d: got %h want %h", n,
                                 {aout4, bout4, cout4, k_last4, row4, col4}, exp4[n]);
                    end
                end
                n++;
            end
        end
        checks++;
        if (n != 40 || nd != 1) begin
            errors++; $display("FAIL bp_count: got beats %0d done %0d want 40 1", n, nd);
        end
        out_ready4 = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_start_ignored();
        int n = 0, nd = 0, post = 0;
        bit busy_again = 1'b0;
        out_ready4 = 1'b1;
        start4 = 1'b1;
        for (int cyc = 0; cyc < 300 && post < 5; cyc++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (nd > 0) begin
                post++;
                if (busy4 || out_valid4) busy_again = 1'b1;
            end
            if (done4) begin nd++; start4 = 1'b1; end
            if (out_valid4) begin
                if (n < 40) begin
                    checks++;
                    if ({aout4, bout4, cout4, k_last4, row4, col4} !== exp4[n]) begin
                        errors++;
                        $display("FAIL ign_beat %0d: got %h want %h", n,
                                 {aout4, bout4, cout4, k_last4, row4, col4}, exp4[n]);
                    end
                end
                if (n == 5 || n == 20) start4 = 1'b1;
                n++;
            end
        end
        checks++;
        if (n != 40 || nd != 1) begin
            errors++; $display("FAIL ign_count: got beats %0d done %0d want 40 1", n, nd);
        end
        checks++;
        if (busy_again) begin errors++; $display("FAIL ign_restart: got 1 want 0"); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n = 0, nd = 0;
        out_ready4 = 1'b1;
        start4 = 1'b1;
        for (int cyc = 0; cyc < 100 && n < 7; cyc++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (out_valid4 && out_ready4) n++;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid4, busy4, rd_en4} !== 3'b000) begin
            errors++; $display("FAIL rst_mid_ctrl: got %b want 000", {out_valid4, busy4, rd_en4});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        checks++;
        if (out_valid4 !== 1'b0) begin errors++; $display("FAIL rst_first_early: got 1 want 0"); end
        @(negedge clk);
        checks++;
        if (out_valid4 !== 1'b1 || {aout4, bout4, cout4, k_last4, row4, col4} !== exp4[0]) begin
            errors++;
            $display("FAIL rst_first_beat: got v=%0b %h want v=1 %h", out_valid4,
                     {aout4, bout4, cout4, k_last4, row4, col4}, exp4[0]);
        end
        n = 0;
        for (int cyc = 0; cyc < 200 && nd == 0; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (done4) nd++;
            if (out_valid4) n++;
        end
        checks++;
        if (n != 40 || nd != 1) begin
            errors++; $display("FAIL rst_rerun: got beats %0d done %0d want 40 1", n, nd);
        end
        repeat (2) @(negedge clk);
    endtask

`ifdef SYMM_FETCH_STALL_CNT_EN
    task automatic test_stall_cnt();
        int nd = 0, st = 0;
        out_ready2 = 1'b1;
        start2 = 1'b1;
        for (int cyc = 0; cyc < 60 && nd == 0; cyc++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (done2) begin
                nd++;
                checks++;
                if (stall2 !== 32'd3) begin
                    errors++; $display("FAIL stall_cnt: got %0d want 3", stall2);
                end
            end
            if (out_valid2 && st < 3) begin
                out_ready2 = 1'b0;
                st++;
            end else begin
                out_ready2 = 1'b1;
            end
        end
        checks++;
        if (nd != 1) begin errors++; $display("FAIL stall_done: got %0d want 1", nd); end
        repeat (2) @(negedge clk);
    endtask
`endif

    initial begin
        build_model();
        test_reset();
        test_basic_n2();
        test_stream_n4();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
`ifdef SYMM_FETCH_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/symm_fetch.md
Name: symm_fetch

Overview:
- Operand fetch sequencer placed directly upstream of the symmetric-matrix accumulate stage.
- Walks the lower triangle (j <= i) of an N x N result and the inner dimension k.
- For each step it reads A[i][k], B[k][j] and C[i][j] from synchronous-read operand memories.
- Streams them as Aout/Bout/Cout beats under valid/ready, with k_last marking the end of each dot product.

Parameters:
- N, 8: result matrix dimension (rows = cols); N >= 1.
- K, 8: inner dimension (A is N x K row-major, B is K x N row-major); K >= 1.
- DW, 32: operand data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a pass when idle.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the final beat is accepted.
- a_addr  out  clog2(N*K)  A memory address = i*K+k.
- b_addr  out  clog2(K*N)  B memory address = k*N+j.
- c_addr  out  clog2(N*N)  C memory address = i*N+j.
- rd_en  out  1  read strobe shared by all three memories.
- a_rdata, b_rdata, c_rdata  in  DW  read data, valid exactly 1 cycle after rd_en.
- out_valid  out  1  beat available.
- out_ready  in  1  consumer accepts the beat when out_valid && out_ready.
- Aout, Bout, Cout  out  DW  operand beat.
- k_last  out  1  beat is k = K-1 for the current (i,j).
- row_i, col_j  out  clog2(N)  output element indices carried with the beat.

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, out_valid=0; all addresses, data and index outputs = 0; FSM=IDLE; buffer empty; in-flight flag cleared.
- FSM states:
  - IDLE: start -> FETCH; counters i=j=k=0, busy=1.
  - FETCH: issues reads; after the read for (N-1,N-1,K-1) is issued -> DRAIN.
  - DRAIN: waits until the buffer is empty and the last beat is accepted -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Loop order, k innermost: for i in 0..N-1, j in 0..i, k in 0..K-1.
  - k wraps to 0 at K-1 and increments j.
  - j wraps to 0 at j==i and increments i.
- Total beats per pass = K*N*(N+1)/2.
- Buffering: 2-entry output FIFO plus at most one in-flight read.
  - Issue a read only if (fifo_count + inflight - pop) < 2.
  - The FIFO writes captured rdata plus the beat's k_last/row_i/col_j on the cycle after rd_en.
- Throughput: 1 beat/cycle when out_ready is held high.
- Latency: first out_valid asserts 2 cycles after the start cycle.
- Backpressure: while out_valid && !out_ready, the Aout/Bout/Cout/k_last/row_i/col_j beat is held stable. No beat is dropped, duplicated or reordered.
- start while busy is ignored, including in DONE.
- Simultaneous FIFO push and pop at count 2 cannot occur (guaranteed by the issue rule). Push and pop in the same cycle at count 1 keeps the count at 1.
- Reset mid-operation:
  - Immediate return to IDLE, FIFO flushed, in-flight cleared; read data arriving after reset is discarded.
  - The next start restarts at (0,0,0).
- N=1: single element (0,0), K beats.
- K=1: every beat has k_last=1.

Optional Feature:
- Macro: SYMM_FETCH_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt, 32 bits.
  - Counts cycles with out_valid && !out_ready since the last accepted start.
  - Cleared on start acceptance and on reset; saturates at all-ones.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package symm_pkg:
  - DW default constant.
  - Index-width helper function (clog2 wrapper).
  - Packed beat typedef {a, b, c, k_last, row_i, col_j}.
  - FSM state enum {IDLE, FETCH, DRAIN, DONE}.
- One sub-module: symm_fetch_fifo, a 2-entry beat FIFO with count, push, pop and flush.

Test Plan:
- N=2, K=2, A[r][c]=10r+c, B[r][c]=100+10r+c, C[r][c]=200+10r+c, out_ready=1 -> 6 beats:
  - (i,j,k) = (0,0,0),(0,0,1),(1,0,0),(1,0,1),(1,1,0),(1,1,1).
  - Aout 0,1,10,11,10,11; Bout 100,110,100,110,101,111; Cout 200,200,210,210,211,211.
  - k_last on beats 2, 4 and 6.
- N=4, K=4, out_ready=1 -> 40 consecutive out_valid cycles starting 2 cycles after start; done pulses exactly once, 1 cycle after the 40th beat; busy low the next cycle.
- N=4, K=4, out_ready held low for 5 cycles at beat 3, then toggled every cycle -> beat 3 held stable throughout; the full 40-beat sequence matches the golden model with no loss.
- start pulsed at beats 5 and 20 during a pass -> ignored; exactly one done; beat count is still 40.
- rst_n asserted at beat 7 -> out_valid=0 and busy=0 immediately; a new start yields the first beat (0,0,0).
- With SYMM_FETCH_STALL_CNT_EN, N=2, K=2, out_ready low for 3 cycles while valid -> stall_cnt=3 at done.
